// File: rtl/lcd_write_queue_pkg.sv
// Shared LCD definitions: data width, default queue geometry, memory-mapped addresses
// and the status word layout the CPU reads back.
package lcd_write_queue_pkg;

   localparam int LCD_DATA_W  = 16;
   localparam int LCDQ_ADDR_W = 3;
   localparam int LCDQ_DEPTH  = 1 << LCDQ_ADDR_W;

   localparam logic [31:0] LCD_DATA_ADDR   = 32'h0000_FF00;
   localparam logic [31:0] LCD_STATUS_ADDR = 32'h0000_FF04;

   typedef struct packed {
      logic                   overflow;
      logic                   full;
      logic                   empty;
      logic [LCDQ_ADDR_W:0]   count;
   } lcdq_status_t;

   // Status register image, zero-extended to the CPU bus width.
   function automatic logic [31:0] lcdq_status_word(input lcdq_status_t s);
      return {{(32 - $bits(lcdq_status_t)){1'b0}}, s};
   endfunction

endpackage

// File: rtl/lcdq_storage.sv
// Queue storage: DEPTH x DATA register array with one synchronous write port
// and one combinational read port.
module lcdq_storage
   import lcd_write_queue_pkg::*;
#(
   parameter int DATA  = LCD_DATA_W,
   parameter int ADDR  = LCDQ_ADDR_W,
   parameter int DEPTH = LCDQ_DEPTH
) (
   input  logic            clk,
   input  logic            we,
   input  logic [ADDR-1:0] waddr,
   input  logic [DATA-1:0] wdata,
   input  logic [ADDR-1:0] raddr,
   output logic [DATA-1:0] rdata
);

   logic [DATA-1:0] mem_q [DEPTH];
   logic [DATA-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   // Contents are left unreset; the control logic never exposes an unwritten slot.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/lcd_write_queue.sv
// First-word-fall-through LCD write queue between the memory controller and lcd_ctrl.
// Optional sticky drop flag: define LCDQ_OVERFLOW_STICKY_EN to add the overflow port.
module lcd_write_queue
   import lcd_write_queue_pkg::*;
#(
   parameter int DATA  = LCD_DATA_W,
   parameter int ADDR  = LCDQ_ADDR_W,
   parameter int DEPTH = LCDQ_DEPTH
) (
   input  logic            CLK_50MHZ,
   input  logic            reset,
   input  logic            wr_en,
   input  logic [DATA-1:0] wr_data,
   input  logic            flush,
   output logic [DATA-1:0] out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            full,
   output logic            empty,
   output logic [ADDR:0]   count
`ifdef LCDQ_OVERFLOW_STICKY_EN
   ,output logic           overflow
`endif
);

   localparam logic [ADDR:0] PTR_ONE = {{ADDR{1'b0}}, 1'b1};

   logic [ADDR:0]   wp_q, wp_d;
   logic [ADDR:0]   rp_q, rp_d;
   logic [ADDR:0]   count_q, count_d;
   logic            empty_q, empty_d;
   logic            full_q, full_d;
   logic            push, pop, we;
   logic [DATA-1:0] head_data;

   // Handshake: a word leaves on any rising edge where out_valid and out_ready are both 1;
   // out_valid never depends on out_ready, and out_data holds while valid and not ready.
   assign pop  = ~empty_q & out_ready;
   assign push = wr_en & (~full_q | pop);
   assign we   = push & ~flush;

   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (flush) begin
         rp_d    = wp_q;
         count_d = '0;
      end else begin
         if (push) begin
            wp_d = wp_q + PTR_ONE;
         end
         if (pop) begin
            rp_d = rp_q + PTR_ONE;
         end
         count_d = count_q + (push ? PTR_ONE : '0) - (pop ? PTR_ONE : '0);
      end
      // Flags come from the next pointers so they stay registered yet always agree with them.
      empty_d = (wp_d == rp_d);
      full_d  = (wp_d[ADDR] != rp_d[ADDR]) && (wp_d[ADDR-1:0] == rp_d[ADDR-1:0]);
   end

   always_ff @(posedge CLK_50MHZ) begin
      if (!reset) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         empty_q <= empty_d;
         full_q  <= full_d;
      end
   end

`ifdef LCDQ_OVERFLOW_STICKY_EN
   logic overflow_q, overflow_d;

   always_comb begin
      overflow_d = overflow_q;
      if (flush) begin
         overflow_d = 1'b0;
      end else if (wr_en & full_q & ~pop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge CLK_50MHZ) begin
      if (!reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;
`endif

   lcdq_storage #(
      .DATA  (DATA),
      .ADDR  (ADDR),
      .DEPTH (DEPTH)
   ) u_storage (
      .clk   (CLK_50MHZ),
      .we    (we),
      .waddr (wp_q[ADDR-1:0]),
      .wdata (wr_data),
      .raddr (rp_q[ADDR-1:0]),
      .rdata (head_data)
   );

   // Masked to zero while empty so stale array contents never appear on the bus.
   assign out_data  = empty_q ? '0 : head_data;
   assign out_valid = ~empty_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign count     = count_q;

endmodule

// File: tb/tb_lcd_write_queue.sv
// Bench for lcd_write_queue: reference occupancy model plus expected-word queue,
// checked every cycle, with directed scenarios and a random burst.
module tb_lcd_write_queue;

   localparam int W = 16;

   logic          CLK_50MHZ;
   logic          reset;
   logic          wr_en;
   logic [W-1:0]  wr_data;
   logic          flush;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic          full;
   logic          empty;
   logic [3:0]    count;
`ifdef LCDQ_OVERFLOW_STICKY_EN
   logic          overflow;
`endif

   lcd_write_queue dut (
      .CLK_50MHZ (CLK_50MHZ),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .flush     (flush),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .full      (full),
      .empty     (empty),
      .count     (count)
`ifdef LCDQ_OVERFLOW_STICKY_EN
      ,.overflow (overflow)
`endif
   );

   // ---------------- clock / reset ----------------
   initial begin
      CLK_50MHZ = 1'b0;
      forever #10 CLK_50MHZ = ~CLK_50MHZ;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int           m_count  = 0;
   logic         m_ovf    = 1'b0;
   logic         mon_en   = 1'b0;
   logic         m_pop;
   logic         m_push;
   logic [W-1:0] last_popped = '0;
   logic [W-1:0] exp_word;

   // Compare the registered state, then advance the model across the coming edge.
   always @(negedge CLK_50MHZ) begin
      if (mon_en) begin
         check("count", {28'd0, count}, m_count);
         check("empty", {31'd0, empty}, (m_count == 0));
         check("full", {31'd0, full}, (m_count == 8));
         check("out_valid", {31'd0, out_valid}, (m_count != 0));
`ifdef LCDQ_OVERFLOW_STICKY_EN
         check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
`endif
         if (!reset || flush) begin
            exp_q.delete();
            m_count = 0;
            m_ovf   = 1'b0;
         end else begin
            m_pop  = (m_count > 0) && out_ready;
            m_push = wr_en && ((m_count < 8) || m_pop);
            if (wr_en && (m_count == 8) && !m_pop) m_ovf = 1'b1;
            if (m_pop) begin
               exp_word = exp_q.pop_front();
               check("out_data", {16'd0, out_data}, {16'd0, exp_word});
               last_popped = exp_word;
            end
            if (m_push) exp_q.push_back(wr_data);
            m_count = m_count + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge CLK_50MHZ);
      #1;
   endtask

   task automatic push_word(input logic [W-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (m_count == 0) break;
         step();
      end
      out_ready = 1'b0;
      check("drain_empty", {31'd0, empty}, 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset     = 1'b0;
      wr_en     = 1'b1;
      wr_data   = 16'hBEEF;
      flush     = 1'b0;
      out_ready = 1'b0;

      // 1. reset held two cycles with wr_en asserted
      step();
      mon_en = 1'b1;
      step();
      reset = 1'b1;
      wr_en = 1'b0;
      step();
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_count", {28'd0, count}, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_data", {16'd0, out_data}, 32'd0);

      // 2. one-cycle latency, held while not ready
      push_word(16'h0041);
      check("lat_valid", {31'd0, out_valid}, 32'd1);
      check("lat_data", {16'd0, out_data}, 32'h0041);
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_data", {16'd0, out_data}, 32'h0041);
         check("hold_count", {28'd0, count}, 32'd1);
      end
      drain();

      // 3. fill to full, ninth push dropped
      for (int i = 1; i <= 9; i++) begin
         push_word(W'(i));
         if (i == 8) begin
            check("fill_full", {31'd0, full}, 32'd1);
            check("fill_count", {28'd0, count}, 32'd8);
         end
      end
      check("drop_count", {28'd0, count}, 32'd8);
      check("drop_head", {16'd0, out_data}, 32'h0001);
`ifdef LCDQ_OVERFLOW_STICKY_EN
      check("ovf_set", {31'd0, overflow}, 32'd1);
`endif
      drain();
      check("fill_last", {16'd0, last_popped}, 32'h0008);

      // 4. simultaneous push and pop while full
      for (int i = 1; i <= 8; i++) push_word(W'(i));
      out_ready = 1'b1;
      push_word(16'h00AA);
      out_ready = 1'b0;
      check("pp_count", {28'd0, count}, 32'd8);
      check("pp_head", {16'd0, out_data}, 32'h0002);
      drain();
      check("pp_last", {16'd0, last_popped}, 32'h00AA);

      // 5. wrap with out_ready toggling
      for (int i = 0; i < 20; i++) begin
         out_ready = i[0];
         push_word(W'($urandom_range(0, 16'hFFFF)));
      end
      drain();

      // random burst
      for (int i = 0; i < 200; i++) begin
         wr_en     = ($urandom_range(0, 3) != 0);
         wr_data   = W'($urandom_range(0, 16'hFFFF));
         out_ready = ($urandom_range(0, 2) == 0);
         step();
      end
      wr_en = 1'b0;
      drain();

      // 6a. flush with a concurrent push and pop request
      for (int i = 0; i < 4; i++) push_word(16'h0100 + W'(i));
      flush     = 1'b1;
      wr_en     = 1'b1;
      wr_data   = 16'h0DEF;
      out_ready = 1'b1;
      step();
      flush     = 1'b0;
      wr_en     = 1'b0;
      out_ready = 1'b0;
      check("flush_count", {28'd0, count}, 32'd0);
      check("flush_empty", {31'd0, empty}, 32'd1);
`ifdef LCDQ_OVERFLOW_STICKY_EN
      check("flush_ovf", {31'd0, overflow}, 32'd0);
`endif

      // 6b. reset during a pop, then confirm no stale word reappears
      for (int i = 0; i < 3; i++) push_word(16'h0200 + W'(i));
      out_ready = 1'b1;
      reset     = 1'b0;
      step();
      reset     = 1'b1;
      out_ready = 1'b0;
      check("mrst_empty", {31'd0, empty}, 32'd1);
      check("mrst_count", {28'd0, count}, 32'd0);
      push_word(16'h0333);
      check("mrst_head", {16'd0, out_data}, 32'h0333);
      drain();
      check("mrst_last", {16'd0, last_popped}, 32'h0333);

      step();
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
